ac_frame_decoder: RTL
=====================

AC_FRAME_DECODER -- requirements
Module: ac_frame_decoder

Interface
REQ-001 Parameter EXP_LEN, default 64, required received bit count for a valid frame.
REQ-002 Parameter TEMP_BASE, default 16, degrees C added to the raw temperature field.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 frame_valid  input  1  upstream IR receiver frame-ready level.
REQ-006 frame_data  input  128  received bits; bit k = k-th received bit; byte n = frame_data[8n+7:8n].
REQ-007 frame_len  input  33  received bit count.
REQ-008 cmd_ready  input  1  downstream accepts command when high with cmd_valid.
REQ-009 cmd_valid  output  1  decoded command available.
REQ-010 cmd_power  output  1  byte0[3].
REQ-011 cmd_mode  output  3  byte0[2:0].
REQ-012 cmd_fan  output  2  byte0[5:4].
REQ-013 cmd_temp  output  6  byte1[3:0] + TEMP_BASE.
REQ-014 err_len_cnt  output  8  saturating count of wrong-length frames.
REQ-015 err_sum_cnt  output  8  saturating count of checksum failures.
REQ-016 drop_cnt  output  8  saturating count of frames arriving while busy.

Function
REQ-017 Block SHALL register frame_valid, frame_data, frame_len every cycle; a frame event SHALL occur when frame_valid=1 and (registered frame_valid=0 or frame_data or frame_len differs from the registered copy).
REQ-018 States SHALL be IDLE, SUM, CHECK, HOLD; encoding free; unreachable encodings SHALL return to IDLE.
REQ-019 IDLE: on frame event, latch frame_data[63:0] and frame_len, clear checksum accumulator, byte index=0, go to SUM.
REQ-020 SUM: each cycle add latched byte[index] to 8-bit accumulator modulo 256, index+1; after byte 6 (7 cycles) go to CHECK.
REQ-021 CHECK (one cycle): if latched len != EXP_LEN, err_len_cnt+1, go IDLE; else if accumulator != byte7, err_sum_cnt+1, go IDLE; else load cmd_* fields, go HOLD.
REQ-022 Length check SHALL take priority; a frame failing both SHALL increment only err_len_cnt.
REQ-023 HOLD: cmd_valid=1; cmd_* SHALL stay stable until cmd_valid and cmd_ready both high at a clock edge, then go IDLE with cmd_valid=0 next cycle.
REQ-024 Latency: event sampled at edge E; cmd_valid SHALL be high from edge E+9 onward; minimum event-to-event throughput 10 cycles with cmd_ready held high.
REQ-025 cmd_temp SHALL be 6-bit unsigned, range TEMP_BASE..TEMP_BASE+15, no saturation.
REQ-026 A frame event in SUM, CHECK or HOLD SHALL be discarded and drop_cnt+1; current frame processing unaffected.
REQ-027 All counters SHALL saturate at 255 and never wrap.
REQ-028 frame_data bits 127:64 SHALL be ignored except for event detection.
REQ-029 cmd_* outputs SHALL keep last accepted values in IDLE; only cmd_valid qualifies them.

Reset
REQ-030 rst_n low SHALL asynchronously force state IDLE, cmd_valid=0, all cmd_* fields 0, all counters 0, registered input copies 0, accumulator and index 0.
REQ-031 Reset asserted mid-SUM or mid-HOLD SHALL abandon the frame with no counter change; first event after release SHALL be processed normally.
REQ-032 After release, frame_valid already high with nonzero data SHALL count as one event (registered copy is 0).

Verification
REQ-033 Valid frame: len=64, data[63:0]=0x2100000000000819, cmd_ready=1 -> cmd_valid high at E+9 for 1 cycle, power=1, mode=1, fan=1, temp=24, all counters 0.
REQ-034 Backpressure: same frame, cmd_ready=0 for 20 cycles then 1 -> cmd_valid high 21 cycles, fields stable; second distinct frame sent during hold -> drop_cnt=1.
REQ-035 Checksum error: byte7=0x22 -> no cmd_valid, err_sum_cnt=1; len=63 with bad checksum -> err_len_cnt=1, err_sum_cnt unchanged.
REQ-036 Upstream level held high: frame_valid stays 1, data unchanged 100 cycles -> exactly one command; data changes -> second command.
REQ-037 Saturation: 300 wrong-length frames -> err_len_cnt=255.
REQ-038 Reset at E+4 -> all outputs 0 immediately, no cmd_valid; next frame decoded with latency 9.

Source files
------------

// File: rtl/ac_frame_decoder.sv
// ac_frame_decoder
//   Decodes 64-bit air-conditioner IR frames delivered by an upstream
//   receiver. A frame is accepted when its bit count equals EXP_LEN and the
//   modulo-256 sum of bytes 0..6 equals byte 7. Good frames are presented
//   as a command on a valid/ready output. Length errors, checksum errors and
//   frames arriving while busy are counted in saturating 8-bit counters.
//
// Ports
//   clk          system clock (50 MHz)
//   rst_n        asynchronous active-low reset
//   frame_valid  upstream frame-ready level
//   frame_data   received bits, bit k = k-th bit, byte n = [8n+7:8n]
//   frame_len    received bit count
//   cmd_ready    downstream accept
//   cmd_valid    decoded command available
//   cmd_power    byte0[3]
//   cmd_mode     byte0[2:0]
//   cmd_fan      byte0[5:4]
//   cmd_temp     byte1[3:0] + TEMP_BASE (6-bit, wraps, no saturation)
//   err_len_cnt  wrong-length frame count (saturating)
//   err_sum_cnt  checksum failure count (saturating)
//   drop_cnt     frames discarded while busy (saturating)
//   dbg_state    current FSM state
//
// Handshake: cmd_valid rises when a command is loaded and stays high with
// cmd_* stable until a clock edge where cmd_valid && cmd_ready; that edge is
// the transfer, and cmd_valid is low the following cycle. cmd_valid never
// depends combinationally on cmd_ready.
//
// Timing: the frame event is sampled at edge E into evt_q together with the
// registered input copy. IDLE latches the frame at E+1, SUM runs E+2..E+8,
// CHECK resolves at E+9, so cmd_valid is high from E+9.

module ac_frame_decoder #(
    parameter int EXP_LEN   = 64,
    parameter int TEMP_BASE = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_valid,
    input  logic [127:0] frame_data,
    input  logic [32:0]  frame_len,
    input  logic         cmd_ready,
    output logic         cmd_valid,
    output logic         cmd_power,
    output logic [2:0]   cmd_mode,
    output logic [1:0]   cmd_fan,
    output logic [5:0]   cmd_temp,
    output logic [7:0]   err_len_cnt,
    output logic [7:0]   err_sum_cnt,
    output logic [7:0]   drop_cnt,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SUM   = 2'd1,
        CHECK = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, next_state;

    // Registered copy of the upstream inputs, used for change detection.
    logic         fv_q;
    logic [127:0] fd_q;
    logic [32:0]  fl_q;
    logic         evt_q;
    logic         frame_evt;

    // Latched frame and checksum datapath.
    logic [63:0]  lat_data;
    logic [32:0]  lat_len;
    logic [7:0]   acc;
    logic [2:0]   idx;
    logic [7:0]   cur_byte;

    // FSM strobes.
    logic do_latch;
    logic do_sum;
    logic len_err;
    logic sum_err;
    logic load_cmd;
    logic drop;

    localparam logic [32:0] EXP_LEN_C   = 33'(EXP_LEN);
    localparam logic [5:0]  TEMP_BASE_C = 6'(TEMP_BASE);

    // A held level with unchanged contents is the same frame; only a rising
    // level or a content change starts a new one. Upper data bits take part
    // here even though they are never decoded.
    assign frame_evt = frame_valid &&
                       (!fv_q || (frame_data != fd_q) || (frame_len != fl_q));

    assign cur_byte  = lat_data[{idx, 3'b000} +: 8];
    assign cmd_valid = (state == HOLD);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fv_q  <= 1'b0;
            fd_q  <= '0;
            fl_q  <= '0;
            evt_q <= 1'b0;
        end else begin
            fv_q  <= frame_valid;
            fd_q  <= frame_data;
            fl_q  <= frame_len;
            evt_q <= frame_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        do_latch   = 1'b0;
        do_sum     = 1'b0;
        len_err    = 1'b0;
        sum_err    = 1'b0;
        load_cmd   = 1'b0;
        drop       = 1'b0;
        case (state)
            IDLE: begin
                next_state = IDLE;
                if (evt_q) begin
                    do_latch   = 1'b1;
                    next_state = SUM;
                end
            end
            SUM: begin
                drop       = evt_q;
                do_sum     = 1'b1;
                next_state = (idx == 3'd6) ? CHECK : SUM;
            end
            CHECK: begin
                drop       = evt_q;
                next_state = IDLE;
                // Length is judged first so a doubly bad frame counts once.
                if (lat_len != EXP_LEN_C) begin
                    len_err = 1'b1;
                end else if (acc != lat_data[63:56]) begin
                    sum_err = 1'b1;
                end else begin
                    load_cmd   = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                drop       = evt_q;
                next_state = cmd_ready ? IDLE : HOLD;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_data <= '0;
            lat_len  <= '0;
            acc      <= '0;
            idx      <= '0;
        end else if (do_latch) begin
            lat_data <= fd_q[63:0];
            lat_len  <= fl_q;
            acc      <= '0;
            idx      <= '0;
        end else if (do_sum) begin
            acc <= acc + cur_byte;
            idx <= idx + 3'd1;
        end
    end

    // Command fields persist through IDLE; cmd_valid alone qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_power <= 1'b0;
            cmd_mode  <= '0;
            cmd_fan   <= '0;
            cmd_temp  <= '0;
        end else if (load_cmd) begin
            cmd_power <= lat_data[3];
            cmd_mode  <= lat_data[2:0];
            cmd_fan   <= lat_data[5:4];
            cmd_temp  <= {2'b00, lat_data[11:8]} + TEMP_BASE_C;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len_cnt <= '0;
            err_sum_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (len_err && (err_len_cnt != 8'hFF)) err_len_cnt <= err_len_cnt + 8'd1;
            if (sum_err && (err_sum_cnt != 8'hFF)) err_sum_cnt <= err_sum_cnt + 8'd1;
            if (drop && (drop_cnt != 8'hFF))       drop_cnt    <= drop_cnt + 8'd1;
        end
    end

endmodule
